// File: rtl/bin2bcd_disp_if.sv
// Input handshake bundle for bin2bcd_disp: binary value plus valid/ready.
// No latency of its own; purely a grouping of wires.
// Producer holds in_valid/in_data until in_ready is seen high on a clock edge.
interface bin2bcd_disp_if #(
    parameter int IN_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;

    // Upstream side: offers a value and watches for acceptance.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Converter side: consumes the value and reports readiness.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble binary-to-BCD converter driving a packed 7-segment display word.
// Latency: IN_W edges after acceptance for in-range values; one edge for out-of-range values.
// Backpressure: in_ready is low for the whole conversion; out-of-range inputs never stall.
module bin2bcd_disp #(
    parameter int IN_W   = 32,
    parameter int NDIGIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bin2bcd_disp_if.slave         in_if,
    output logic [4*NDIGIT-1:0]   disp_data,
    output logic                  ovf,
    output logic                  update
);

    // Largest value representable in NDIGIT decimal digits, widened so the
    // comparison against the input never truncates.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < n; k++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

    localparam logic [63:0]         MAXVAL = pow10(NDIGIT) - 64'd1;
    localparam int                  CNT_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0]    LAST   = CNT_W'(IN_W - 1);
    localparam logic [4*NDIGIT-1:0] ALL_E  = {NDIGIT{4'hE}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IN_W-1:0]      bin, bin_nxt;
    logic [4*NDIGIT-1:0]  bcd, bcd_nxt;
    logic [4*NDIGIT-1:0]  disp_nxt;
    logic                 ovf_nxt;
    logic                 update_nxt;

    logic                 accept;
    logic                 in_over;
    logic [4*NDIGIT-1:0]  bcd_shift;
    logic [IN_W-1:0]      bin_shift;
    logic [3:0]           digit_adj;
    logic                 carry;

    // Ready only while idle and out of reset, so nothing is taken on a reset edge.
    assign in_if.in_ready = (state == IDLE) && !rst;
    assign accept         = in_if.in_valid && (state == IDLE) && !rst;
    assign in_over        = 64'(in_if.in_data) > MAXVAL;
    assign bin_shift      = {bin[IN_W-2:0], 1'b0};

    // One double-dabble step: add 3 to every digit >= 5, then shift {bcd,bin} left by one.
    // The carry chain threads each digit's top bit into the next digit; the final carry
    // out of the top digit is dropped because in-range inputs never produce it.
    always_comb begin
        bcd_shift = '0;
        digit_adj = 4'd0;
        carry     = bin[IN_W-1];
        for (int i = 0; i < NDIGIT; i++) begin
            digit_adj = bcd[4*i +: 4];
            if (digit_adj >= 4'd5) begin
                digit_adj = digit_adj + 4'd3;
            end
            bcd_shift[4*i +: 4] = {digit_adj[2:0], carry};
            carry               = digit_adj[3];
        end
    end

    // Next-state and datapath decisions: accept/overflow in IDLE, iterate in CONV.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bin_nxt    = bin;
        bcd_nxt    = bcd;
        disp_nxt   = disp_data;
        ovf_nxt    = ovf;
        update_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_over) begin
                        // Out-of-range values show all 'E' at once and never leave IDLE.
                        disp_nxt   = ALL_E;
                        ovf_nxt    = 1'b1;
                        update_nxt = 1'b1;
                    end else begin
                        // Previous result stays on display until this conversion lands.
                        bin_nxt   = in_if.in_data;
                        bcd_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = CONV;
                    end
                end
            end
            CONV: begin
                bcd_nxt = bcd_shift;
                bin_nxt = bin_shift;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    disp_nxt   = bcd_shift;
                    ovf_nxt    = 1'b0;
                    update_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers and display outputs; reset aborts any conversion and blanks to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bin       <= '0;
            bcd       <= '0;
            disp_data <= '0;
            ovf       <= 1'b0;
            update    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            bin       <= bin_nxt;
            bcd       <= bcd_nxt;
            disp_data <= disp_nxt;
            ovf       <= ovf_nxt;
            update    <= update_nxt;
        end
    end

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Testbench for bin2bcd_disp: directed scenarios plus randomized values against a decimal model.
// Inputs change on the falling edge or just after the rising edge; outputs are sampled on the falling edge.
// Waits on the converter are bounded by a cycle budget.
module tb_bin2bcd_disp;

    localparam int IN_W   = 32;
    localparam int NDIGIT = 8;
    localparam logic [31:0] MAXV = 32'd99999999;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] disp_data;
    logic        ovf;
    logic        update;

    int checks = 0;
    int errors = 0;

    bin2bcd_disp_if #(.IN_W(IN_W)) in_if();

    bin2bcd_disp #(.IN_W(IN_W), .NDIGIT(NDIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .disp_data (disp_data),
        .ovf       (ovf),
        .update    (update)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division, or all 'E' when the value needs more digits.
    function automatic logic [31:0] ref_disp(input logic [31:0] v);
        logic [31:0] r;
        longint unsigned x;
        if (v > MAXV) return 32'hEEEEEEEE;
        r = 32'd0;
        x = longint'(v);
        for (int d = 0; d < NDIGIT; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 32'd0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_if.in_ready !== 1'b0 || disp_data !== 32'h0 || ovf !== 1'b0 || update !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b disp=%h ovf=%b upd=%b required 0 00000000 0 0",
                     in_if.in_ready, disp_data, ovf, update);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_if.in_ready !== 1'b1 || disp_data !== 32'h0 || ovf !== 1'b0 || update !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle%0d: ready=%b disp=%h ovf=%b upd=%b required 1 00000000 0 0",
                         i, in_if.in_ready, disp_data, ovf, update);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'd12345678;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            @(negedge clk);
            checks++;
            if (in_if.in_ready !== 1'b0 || update !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy%0d: ready=%b upd=%b required 0 0", i, in_if.in_ready, update);
            end
        end
        @(negedge clk);
        checks++;
        if (disp_data !== 32'h12345678 || update !== 1'b1 || ovf !== 1'b0 || in_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_result: disp=%h upd=%b ovf=%b ready=%b required 12345678 1 0 1",
                     disp_data, update, ovf, in_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if (update !== 1'b0 || disp_data !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_hold: disp=%h upd=%b required 12345678 0", disp_data, update);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'd99999999;
        @(posedge clk);
        for (int j = 0; j <= 2 * (IN_W + 1); j++) begin
            @(negedge clk);
            checks++;
            if (j == IN_W) begin
                if (disp_data !== 32'h99999999 || update !== 1'b1 || in_if.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first: disp=%h upd=%b ready=%b required 99999999 1 1",
                             disp_data, update, in_if.in_ready);
                end
                in_if.in_data = 32'd0;
            end else if (j == 2 * IN_W + 1) begin
                if (disp_data !== 32'h00000000 || update !== 1'b1 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second: disp=%h upd=%b ovf=%b required 00000000 1 0",
                             disp_data, update, ovf);
                end
                in_if.in_valid = 1'b0;
            end else if (j == 2 * (IN_W + 1)) begin
                if (update !== 1'b0 || in_if.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_after: upd=%b ready=%b required 0 1", update, in_if.in_ready);
                end
            end else begin
                if (update !== 1'b0 || in_if.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy%0d: upd=%b ready=%b required 0 0", j, update, in_if.in_ready);
                end
            end
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'd100000000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (disp_data !== 32'hEEEEEEEE || ovf !== 1'b1 || update !== 1'b1 || in_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_maxp1: disp=%h ovf=%b upd=%b ready=%b required EEEEEEEE 1 1 1",
                     disp_data, ovf, update, in_if.in_ready);
        end
        in_if.in_data = 32'd7;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            @(negedge clk);
            checks++;
            if (update !== 1'b0 || disp_data !== 32'hEEEEEEEE || ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_keep%0d: disp=%h ovf=%b upd=%b required EEEEEEEE 1 0",
                         i, disp_data, ovf, update);
            end
        end
        @(negedge clk);
        checks++;
        if (disp_data !== 32'h00000007 || ovf !== 1'b0 || update !== 1'b1) begin
            errors++;
            $display("FAIL ovf_then7: disp=%h ovf=%b upd=%b required 00000007 0 1", disp_data, ovf, update);
        end
    endtask

    task automatic test_all_ones();
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'hFFFFFFFF;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (disp_data !== 32'hEEEEEEEE || ovf !== 1'b1 || update !== 1'b1 || in_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL all_ones: disp=%h ovf=%b upd=%b ready=%b required EEEEEEEE 1 1 1",
                     disp_data, ovf, update, in_if.in_ready);
        end
        @(negedge clk);
        checks++;
        if (update !== 1'b0) begin
            errors++;
            $display("FAIL all_ones_pulse: upd=%b required 0", update);
        end
    endtask

    task automatic test_reset_mid_conv();
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'd55555555;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (update !== 1'b0 || in_if.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_busy%0d: upd=%b ready=%b required 0 0", i, update, in_if.in_ready);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (update !== 1'b0 || disp_data !== 32'h0 || ovf !== 1'b0 || in_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: disp=%h ovf=%b upd=%b ready=%b required 00000000 0 0 0",
                     disp_data, ovf, update, in_if.in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < IN_W + 2; i++) begin
            @(negedge clk);
            checks++;
            if (update !== 1'b0 || disp_data !== 32'h0 || in_if.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_idle%0d: disp=%h upd=%b ready=%b required 00000000 0 1",
                         i, disp_data, update, in_if.in_ready);
            end
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = 32'd42;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        repeat (IN_W + 1) @(negedge clk);
        checks++;
        if (disp_data !== 32'h00000042 || update !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrst_42: disp=%h upd=%b ovf=%b required 00000042 1 0", disp_data, update, ovf);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] exp_disp;
        logic        exp_ovf;
        int          lat;
        int          exp_lat;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: v = $urandom();
                1: v = $urandom() % 100000000;
                2: v = $urandom_range(0, 999);
                3: begin
                    case ($urandom_range(0, 3))
                        0: v = 32'd0;
                        1: v = MAXV;
                        2: v = MAXV + 32'd1;
                        default: v = MAXV - 32'd1;
                    endcase
                end
                default: v = 32'd100000000 + ($urandom() % 1000);
            endcase
            exp_disp = ref_disp(v);
            exp_ovf  = (v > MAXV);
            exp_lat  = exp_ovf ? 1 : IN_W + 1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            in_if.in_valid = 1'b1;
            in_if.in_data  = v;
            @(posedge clk);
            #1 in_if.in_valid = 1'b0;
            lat = 0;
            while (lat < IN_W + 8) begin
                @(negedge clk);
                lat++;
                if (update === 1'b1) break;
            end
            checks++;
            if (update !== 1'b1 || lat != exp_lat) begin
                errors++;
                $display("FAIL rand_latency%0d: value=%0d latency=%0d upd=%b required latency %0d",
                         n, v, lat, update, exp_lat);
            end
            checks++;
            if (disp_data !== exp_disp || ovf !== exp_ovf) begin
                errors++;
                $display("FAIL rand_value%0d: value=%0d disp=%h ovf=%b required %h %b",
                         n, v, disp_data, ovf, exp_disp, exp_ovf);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 32'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_all_ones();
        test_reset_mid_conv();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
